imm_ext_pipe: RTL and testbench

Parametrised, pipelined immediate-generation unit for the decode stage of the MIPS pipeline. It takes the raw immediate field of an instruction plus PC+4 and produces an extended immediate and an optional branch or jump target. Results appear through a DEPTH-stage registered pipeline with a valid/ready handshake and flush. It replaces the combinational extender in the ID→EX path.

---
 rtl/imm_ext_pkg.sv | 30 +++
 rtl/imm_ext_if.sv | 31 +++
 rtl/imm_ext_comb.sv | 65 ++++++
 rtl/imm_ext_pipe.sv | 73 +++++++
 tb/tb_imm_ext_pipe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-generation pipeline.
// Contents: ext_op width, the eight extension-mode codes, and the packed
// {imm, tgt} pipeline entry (sized for the widest legal datapath, 64 bits).
package imm_ext_pkg;

  localparam int EXT_OP_W = 3;
  localparam int MAX_W    = 64;

  typedef enum logic [EXT_OP_W-1:0] {
    EXT_ZERO     = 3'd0,
    EXT_SIGNED   = 3'd1,
    EXT_HIGHPOS  = 3'd2,
    EXT_UNSIGNED = 3'd3,
    EXT_SHAMT    = 3'd4,
    EXT_BRANCH   = 3'd5,
    EXT_JUMP     = 3'd6,
    EXT_ILLEGAL  = 3'd7
  } ext_op_e;

  // Bits above DATA_W are always zero; they are trimmed away at the outputs.
  typedef struct packed {
    logic [MAX_W-1:0] imm;
    logic [MAX_W-1:0] tgt;
  } ent_t;

  function automatic logic [MAX_W-1:0] sext16(input logic [15:0] v);
    return {{(MAX_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/imm_ext_if.sv
// Handshake and data bundle between the decode stage and imm_ext_pipe.
// master: the surrounding pipeline (drives inputs, consumes results).
// slave : the immediate unit itself.
interface imm_ext_if #(
  parameter int DATA_W = 32
);
  import imm_ext_pkg::*;

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [25:0]         imm_in;
  logic [EXT_OP_W-1:0] ext_op;
  logic [DATA_W-1:0]   pc_plus4;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   imm_out;
  logic [DATA_W-1:0]   tgt_out;
  logic                err_illegal;

  modport master (
    output flush, in_valid, imm_in, ext_op, pc_plus4, out_ready,
    input  in_ready, out_valid, imm_out, tgt_out, err_illegal
  );

  modport slave (
    input  flush, in_valid, imm_in, ext_op, pc_plus4, out_ready,
    output in_ready, out_valid, imm_out, tgt_out, err_illegal
  );

endinterface

// File: rtl/imm_ext_comb.sv
// Combinational mode decode, immediate extension and branch/jump target.
// Ports: imm_in_i/ext_op_i/pc_plus4_i in; ent_o {imm,tgt} and illegal_o out.
// Target logic is built only when IMM_EXT_TARGET_EN is defined.
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [25:0]         imm_in_i,
  input  logic [EXT_OP_W-1:0] ext_op_i,
  input  logic [DATA_W-1:0]   pc_plus4_i,
  output ent_t                ent_o,
  output logic                illegal_o
);

  logic [15:0]      imm16;
  logic [MAX_W-1:0] s64, z64, pc64, imm64, tgt64;

  assign imm16 = imm_in_i[15:0];
  assign s64   = sext16(imm16);
  assign z64   = {{(MAX_W-16){1'b0}}, imm16};
  assign pc64  = MAX_W'(pc_plus4_i);

  // Everything is formed at 64 bits; low-order results are identical for a
  // 32-bit datapath, so truncation to DATA_W gives the mod-2^DATA_W answer.
  always_comb begin
    imm64     = '0;
    tgt64     = '0;
    illegal_o = 1'b0;
    case (ext_op_e'(ext_op_i))
      EXT_ZERO, EXT_UNSIGNED: imm64 = z64;
      EXT_SIGNED:             imm64 = s64;
      // Bit 31 is imm16[15], so the upper word is its sign extension.
      EXT_HIGHPOS:            imm64 = {{32{imm16[15]}}, imm16, 16'h0000};
      EXT_SHAMT:              imm64 = {59'd0, imm_in_i[10:6]};
      EXT_BRANCH: begin
        imm64 = s64;
`ifdef IMM_EXT_TARGET_EN
        tgt64 = pc64 + (s64 << 2);
`endif
      end
      EXT_JUMP: begin
`ifdef IMM_EXT_TARGET_EN
        imm64 = {38'd0, imm_in_i};
        tgt64 = {pc64[MAX_W-1:28], imm_in_i, 2'b00};
`else
        imm64 = z64;
`endif
      end
      default:                illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    ent_o                 = '0;
    ent_o.imm[DATA_W-1:0] = imm64[DATA_W-1:0];
    ent_o.tgt[DATA_W-1:0] = tgt64[DATA_W-1:0];
  end

  // Upper bits (32-bit build) and the PC/jump field (no-target build) are
  // legitimately unread.
  logic unused_comb;
  assign unused_comb = ^{imm64, tgt64, pc64, imm_in_i};

endmodule

// File: rtl/imm_ext_pipe.sv
// DEPTH-stage registered immediate generator for the ID->EX path.
// Ports: clk, rst_n (sync, active low), bus (imm_ext_if.slave).
// Latency DEPTH cycles; all stages stall together when output is held.
// Optional branch/jump target build: IMM_EXT_TARGET_EN.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_ext_if.slave     bus
);

  ent_t             new_ent;
  logic             new_illegal;
  logic             adv;
  logic [DEPTH-1:0] valid_q, valid_d;
  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic             err_q, err_d;

  imm_ext_comb #(.DATA_W(DATA_W)) u_comb (
    .imm_in_i   (bus.imm_in),
    .ext_op_i   (bus.ext_op),
    .pc_plus4_i (bus.pc_plus4),
    .ent_o      (new_ent),
    .illegal_o  (new_illegal)
  );

  assign adv          = bus.out_ready | ~valid_q[DEPTH-1];
  // Held entries are discarded by reset, so the unit is ready while in reset.
  assign bus.in_ready = adv | ~rst_n;

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (bus.flush) begin
      valid_d = '0;
    end else if (adv) begin
      valid_d[0] = bus.in_valid;
      ent_d[0]   = new_ent;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        ent_d[i]   = ent_q[i-1];
      end
      if (bus.in_valid && new_illegal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign bus.out_valid   = valid_q[DEPTH-1];
  assign bus.imm_out     = ent_q[DEPTH-1].imm[DATA_W-1:0];
  assign bus.tgt_out     = ent_q[DEPTH-1].tgt[DATA_W-1:0];
  assign bus.err_illegal = err_q;

  logic unused_top;
  assign unused_top = ^ent_q[DEPTH-1];

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

`ifdef IMM_EXT_TARGET_EN
  localparam bit TGT_EN = 1'b1;
`else
  localparam bit TGT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  imm_ext_if #(.DATA_W(32)) b1 ();
  imm_ext_if #(.DATA_W(64)) b2 ();
  imm_ext_if #(.DATA_W(32)) b3 ();

  imm_ext_pipe #(.DATA_W(32), .DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  imm_ext_pipe #(.DATA_W(64), .DEPTH(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  imm_ext_pipe #(.DATA_W(32), .DEPTH(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    b1.flush = 0; b1.in_valid = 0; b1.imm_in = '0; b1.ext_op = '0; b1.pc_plus4 = '0; b1.out_ready = 1;
    b2.flush = 0; b2.in_valid = 0; b2.imm_in = '0; b2.ext_op = '0; b2.pc_plus4 = '0; b2.out_ready = 1;
    b3.flush = 0; b3.in_valid = 0; b3.imm_in = '0; b3.ext_op = '0; b3.pc_plus4 = '0; b3.out_ready = 1;

    // Reset state
    tick;
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_imm", b1.imm_out, 0);
    chk("rst_tgt", b1.tgt_out, 0);
    chk("rst_err", b1.err_illegal, 0);
    chk("rst_in_ready", b1.in_ready, 1);
    chk("rst_d3_valid", b3.out_valid, 0);
    rst_n = 1'b1;
    tick;

    // DEPTH=1, 32-bit: every mode
    b1.in_valid = 1; b1.ext_op = 3'd1; b1.imm_in = 26'h0008001;
    tick;
    chk("signed_valid", b1.out_valid, 1);
    chk("signed_imm", b1.imm_out, 64'hFFFF8001);
    chk("signed_tgt", b1.tgt_out, 0);
    b1.ext_op = 3'd0;
    tick;
    chk("zero_imm", b1.imm_out, 64'h00008001);
    b1.ext_op = 3'd3; b1.imm_in = 26'h3FF8001;
    tick;
    chk("unsigned_imm", b1.imm_out, 64'h00008001);
    b1.ext_op = 3'd5; b1.imm_in = 26'h000FFFF; b1.pc_plus4 = 32'h00400010;
    tick;
    chk("branch_imm", b1.imm_out, 64'hFFFFFFFF);
    chk("branch_tgt", b1.tgt_out, TGT_EN ? 64'h0040000C : 64'h0);
    b1.ext_op = 3'd6; b1.imm_in = 26'h0000010; b1.pc_plus4 = 32'hA0000004;
    tick;
    chk("jump_imm", b1.imm_out, 64'h10);
    chk("jump_tgt", b1.tgt_out, TGT_EN ? 64'hA0000040 : 64'h0);
    chk("jump_err", b1.err_illegal, 0);
    b1.ext_op = 3'd4; b1.imm_in = 26'h00007C0;
    tick;
    chk("shamt_imm", b1.imm_out, 64'h1F);
    b1.ext_op = 3'd2; b1.imm_in = 26'h0001234;
    tick;
    chk("highpos32_imm", b1.imm_out, 64'h12340000);
    b1.ext_op = 3'd7; b1.imm_in = 26'h3FFFFFF;
    tick;
    chk("illegal_valid", b1.out_valid, 1);
    chk("illegal_imm", b1.imm_out, 0);
    chk("illegal_tgt", b1.tgt_out, 0);
    chk("illegal_err", b1.err_illegal, 1);
    b1.ext_op = 3'd1; b1.imm_in = 26'h0000001;
    tick;
    chk("after_illegal_imm", b1.imm_out, 64'h1);
    chk("err_sticky", b1.err_illegal, 1);
    b1.in_valid = 0;
    tick;
    chk("drain_valid", b1.out_valid, 0);
    chk("err_sticky2", b1.err_illegal, 1);

    // DEPTH=2, 64-bit: HIGHPOS sign extension and latency
    b2.in_valid = 1; b2.ext_op = 3'd2; b2.imm_in = 26'h0008000;
    tick;
    chk("d2_lat_valid", b2.out_valid, 0);
    b2.ext_op = 3'd1; b2.imm_in = 26'h0008001;
    tick;
    chk("d2_hp_valid", b2.out_valid, 1);
    chk("d2_hp_imm", b2.imm_out, 64'hFFFFFFFF80000000);
    b2.in_valid = 0;
    tick;
    chk("d2_signed_imm", b2.imm_out, 64'hFFFFFFFFFFFF8001);
    tick;
    chk("d2_empty", b2.out_valid, 0);

    // Flush with two entries in flight plus an illegal entry offered
    b2.in_valid = 1; b2.ext_op = 3'd0; b2.imm_in = 26'h000000A;
    tick;
    b2.imm_in = 26'h000000B;
    tick;
    b2.ext_op = 3'd7; b2.imm_in = 26'h000000C; b2.flush = 1;
    tick;
    chk("flush_valid", b2.out_valid, 0);
    chk("flush_no_err", b2.err_illegal, 0);
    b2.flush = 0; b2.in_valid = 0;
    tick;
    chk("flush_valid1", b2.out_valid, 0);
    tick;
    chk("flush_valid2", b2.out_valid, 0);

    // DEPTH=3 backpressure: 5 entries, out_ready low in cycles 4..7
    for (int k = 1; k <= 12; k++) begin
      int idx;
      b3.out_ready = !(k >= 4 && k <= 7);
      b3.in_valid  = (k <= 9);
      b3.ext_op    = 3'd0;
      b3.imm_in    = 26'h100 + 26'((k <= 3) ? k : ((k <= 8) ? 4 : 5));
      #1;
      chk($sformatf("bp_in_ready_c%0d", k), b3.in_ready, (k >= 4 && k <= 7) ? 0 : 1);
      tick;
      chk($sformatf("bp_valid_c%0d", k), b3.out_valid, (k >= 3 && k <= 11) ? 1 : 0);
      idx = (k <= 7) ? 1 : k - 6;
      if (k >= 3 && k <= 11)
        chk($sformatf("bp_data_c%0d", k), b3.imm_out, 64'h100 + 64'(idx));
    end

    // Reset while stalled discards the held entry and clears the error flag
    b1.in_valid = 1; b1.ext_op = 3'd1; b1.imm_in = 26'h0000005;
    tick;
    b1.in_valid = 0; b1.out_ready = 0;
    #1;
    chk("stall_in_ready", b1.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("in_ready_during_rst", b1.in_ready, 1);
    tick;
    rst_n = 1'b1;
    chk("rst2_valid", b1.out_valid, 0);
    chk("rst2_imm", b1.imm_out, 0);
    chk("rst2_tgt", b1.tgt_out, 0);
    chk("rst2_err", b1.err_illegal, 0);
    #1;
    chk("rst2_in_ready", b1.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
